// File: rtl/decode_stage.sv
// RV32I ALU-class decoder with regfile and scoreboard; optional DECODE_STATS_EN adds ISSUE_CNT/STALL_CNT.
// Latency: 1 cycle, and the bundle is registered on the accept edge.
// Backpressure: INSTR_READY drops on an operand hazard or when the held bundle is not taken. There is no skid buffer.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             INSTR_VALID,
    input  logic [31:0]      INSTR,
    input  logic [XLEN-1:0]  PC,
    output logic             INSTR_READY,
    input  logic             WB_EN,
    input  logic [4:0]       WB_RD,
    input  logic [XLEN-1:0]  WB_DATA,
    output logic             DEC_VALID,
    input  logic             DEC_READY,
    output logic [XLEN-1:0]  RS1_VAL,
    output logic [XLEN-1:0]  RS2_VAL,
    output logic [XLEN-1:0]  IMM,
    output logic [4:0]       RD,
    output logic [3:0]       ALU_OP,
    output logic             USE_IMM,
    output logic             REG_WRITE,
    output logic [XLEN-1:0]  DEC_PC,
    output logic             ILLEGAL
`ifdef DECODE_STATS_EN
    ,
    output logic [CNT_W-1:0] ISSUE_CNT,
    output logic [CNT_W-1:0] STALL_CNT
`endif
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            use_imm;
        logic            reg_write;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    logic [XLEN-1:0] rf [32];
    logic [31:0]     pend;
    logic [31:0]     pend_d;
    bundle_t         out_q;
    bundle_t         dec_d;
    logic            out_vld;

    logic [6:0]      opcode;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    logic [2:0]      funct3;
    logic            is_op, is_opimm, is_lui, is_auipc, legal;
    logic            rs1_used, rs2_used, rs1_hz, rs2_hz, hazard, fire_in;
    logic [XLEN-1:0] rs1_rd, rs2_rd, imm_i, imm_u;

    assign opcode = INSTR[6:0];
    assign rd_f   = INSTR[11:7];
    assign funct3 = INSTR[14:12];
    assign rs1_f  = INSTR[19:15];
    assign rs2_f  = INSTR[24:20];
    assign imm_i  = {{20{INSTR[31]}}, INSTR[31:20]};
    assign imm_u  = {INSTR[31:12], 12'b0};

    assign is_op    = (opcode == OPC_OP);
    assign is_opimm = (opcode == OPC_OPIMM);
    assign is_lui   = (opcode == OPC_LUI);
    assign is_auipc = (opcode == OPC_AUIPC);
    assign legal    = is_op | is_opimm | is_lui | is_auipc;
    assign rs1_used = is_op | is_opimm;
    assign rs2_used = is_op;

    // A write-back in flight this cycle is forwarded straight into the operand read.
    assign rs1_rd = (rs1_f == 5'd0) ? '0 : (WB_EN && WB_RD == rs1_f) ? WB_DATA : rf[rs1_f];
    assign rs2_rd = (rs2_f == 5'd0) ? '0 : (WB_EN && WB_RD == rs2_f) ? WB_DATA : rf[rs2_f];

    assign rs1_hz  = rs1_used && (rs1_f != 5'd0) && pend[rs1_f] && !(WB_EN && WB_RD == rs1_f);
    assign rs2_hz  = rs2_used && (rs2_f != 5'd0) && pend[rs2_f] && !(WB_EN && WB_RD == rs2_f);
    assign hazard  = rs1_hz | rs2_hz;

    assign INSTR_READY = RSTN & ~hazard & (~out_vld | DEC_READY);
    assign fire_in     = INSTR_VALID & INSTR_READY;

    always_comb begin
        dec_d         = '0;
        dec_d.pc      = PC;
        dec_d.rd      = rd_f;
        dec_d.illegal = ~legal;
        unique case (opcode)
            OPC_OP: begin
                dec_d.rs1_val = rs1_rd;
                dec_d.rs2_val = rs2_rd;
                dec_d.alu_op  = {INSTR[30], funct3};
            end
            OPC_OPIMM: begin
                dec_d.rs1_val = rs1_rd;
                dec_d.imm     = imm_i;
                dec_d.use_imm = 1'b1;
                dec_d.alu_op  = {(funct3 == 3'b101) & INSTR[30], funct3};
            end
            OPC_LUI: begin
                dec_d.imm     = imm_u;
                dec_d.use_imm = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.rs1_val = PC;
                dec_d.imm     = imm_u;
                dec_d.use_imm = 1'b1;
            end
            default: ;
        endcase
        dec_d.reg_write = legal && (rd_f != 5'd0);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (fire_in) begin
            out_vld <= 1'b1;
            out_q   <= dec_d;
        end else if (DEC_READY) begin
            out_vld <= 1'b0;
        end
    end

    // The set is applied after the clear so a same-register issue and write-back leaves it pending.
    always_comb begin
        pend_d = pend;
        if (WB_EN) pend_d[WB_RD] = 1'b0;
        if (fire_in && dec_d.reg_write) pend_d[rd_f] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) pend <= '0;
        else       pend <= pend_d;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (WB_EN && WB_RD != 5'd0) begin
            rf[WB_RD] <= WB_DATA;
        end
    end

    assign DEC_VALID = out_vld;
    assign RS1_VAL   = out_q.rs1_val;
    assign RS2_VAL   = out_q.rs2_val;
    assign IMM       = out_q.imm;
    assign RD        = out_q.rd;
    assign ALU_OP    = out_q.alu_op;
    assign USE_IMM   = out_q.use_imm;
    assign REG_WRITE = out_q.reg_write;
    assign DEC_PC    = out_q.pc;
    assign ILLEGAL   = out_q.illegal;

`ifdef DECODE_STATS_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ISSUE_CNT <= '0;
            STALL_CNT <= '0;
        end else begin
            if (fire_in)               ISSUE_CNT <= ISSUE_CNT + CNT_W'(1);
            if (INSTR_VALID && hazard) STALL_CNT <= STALL_CNT + CNT_W'(1);
        end
    end
`else
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule
